// File: rtl/alu_result_buffer.sv
// Registered FIFO between the ALU and writeback: holds result/opcode/flags under a
// valid/ready handshake and keeps saturating overflow/error event counts.
module alu_result_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [31:0]       in_result,
  input  logic [3:0]               in_opcode,
  input  logic                     in_overflow,
  input  logic                     in_error,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [31:0]       out_result,
  output logic [3:0]               out_opcode,
  output logic                     out_overflow,
  output logic                     out_error,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [CNT_W-1:0]         ovf_count,
  output logic [CNT_W-1:0]         err_count,
  input  logic                     cnt_clear
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned FILL_W  = PTR_W + 1;
  localparam int unsigned ENTRY_W = 38;

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [FILL_W-1:0]  r_fill;
  logic [CNT_W-1:0]   r_ovf_cnt;
  logic [CNT_W-1:0]   r_err_cnt;

  logic               w_push;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_head;

  assign in_ready  = (r_fill != FILL_W'(DEPTH));
  assign out_valid = (r_fill != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  // Storage carries no reset; only valid entries are ever exposed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_opcode, in_overflow, in_error, in_result};
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + FILL_W'(1);
        2'b01:   r_fill <= r_fill - FILL_W'(1);
        default: r_fill <= r_fill;
      endcase
    end
  end

  // Event counters: clear has priority, increments saturate at all-ones.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_ovf_cnt <= '0;
      r_err_cnt <= '0;
    end else if (cnt_clear) begin
      r_ovf_cnt <= '0;
      r_err_cnt <= '0;
    end else if (w_push) begin
      if (in_overflow && (r_ovf_cnt != '1)) begin
        r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
      end
      if (in_error && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
    end
  end

  assign w_head       = r_mem[r_rd_ptr];
  assign out_result   = out_valid ? w_head[31:0] : '0;
  assign out_error    = out_valid ? w_head[32]   : 1'b0;
  assign out_overflow = out_valid ? w_head[33]   : 1'b0;
  assign out_opcode   = out_valid ? w_head[37:34] : '0;
  assign fill_level   = r_fill;
  assign ovf_count    = r_ovf_cnt;
  assign err_count    = r_err_cnt;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer (DEPTH=4, CNT_W=2).
module tb_alu_result_buffer;

  logic        clk = 1'b0;
  logic        rstN;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [3:0]  in_opcode;
  logic        in_overflow;
  logic        in_error;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_opcode;
  logic        out_overflow;
  logic        out_error;
  logic [2:0]  fill_level;
  logic [1:0]  ovf_count;
  logic [1:0]  err_count;
  logic        cnt_clear;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] v2 [4] = '{32'h7FFF_FFFF, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0001};
  logic [31:0] q [$];

  alu_result_buffer #(.DEPTH(4), .CNT_W(2)) dut (
    .clk(clk), .rstN(rstN),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_opcode(in_opcode), .in_overflow(in_overflow), .in_error(in_error),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_opcode(out_opcode), .out_overflow(out_overflow), .out_error(out_error),
    .fill_level(fill_level), .ovf_count(ovf_count), .err_count(err_count),
    .cnt_clear(cnt_clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pushed;
    int popped;
    int cyc;
    logic mp;
    logic mpop;

    rstN = 1'b0; in_valid = 1'b0; in_result = '0; in_opcode = '0;
    in_overflow = 1'b0; in_error = 1'b0; out_ready = 1'b0; cnt_clear = 1'b0;

    // reset state
    #3;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fill", fill_level, 0);
    chk("rst_ovf", ovf_count, 0);
    chk("rst_err", err_count, 0);
    chk("rst_result", out_result, 0);
    step();
    rstN = 1'b1;
    step();

    // fill to full with consumer stalled, then drain in order
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_result   = v2[i];
      in_opcode   = 4'(i + 3);
      in_overflow = (i == 0);
      in_error    = (i == 1);
      step();
      if (i == 0) begin
        chk("t2_latency_valid", out_valid, 1);
        chk("t2_latency_head", out_result, 32'h7FFF_FFFF);
      end
    end
    chk("t2_fill_full", fill_level, 4);
    chk("t2_in_ready_full", in_ready, 0);
    in_result = 32'hDEAD_BEEF; in_overflow = 1'b1; in_error = 1'b1;
    step();
    chk("t2_ignored_fill", fill_level, 4);
    chk("t2_ignored_ovf", ovf_count, 1);
    chk("t2_ignored_err", err_count, 1);
    in_valid = 1'b0; in_overflow = 1'b0; in_error = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_pop_data", out_result, v2[i]);
      chk("t2_pop_op", out_opcode, 4'(i + 3));
      chk("t2_pop_ovf", out_overflow, (i == 0));
      chk("t2_pop_err", out_error, (i == 1));
      step();
    end
    chk("t2_fill_end", fill_level, 0);
    chk("t2_valid_end", out_valid, 0);
    chk("t2_empty_result", out_result, 0);

    // steady stream at fill 2, then push+pop while full only pops
    out_ready = 1'b0; in_valid = 1'b1;
    in_result = 32'd10; step();
    in_result = 32'd11; step();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_result = 32'(12 + k);
      chk("t3_fill_steady", fill_level, 2);
      chk("t3_stream_data", out_result, 32'(10 + k));
      step();
    end
    out_ready = 1'b0;
    in_result = 32'd18; step();
    in_result = 32'd19; step();
    in_result = 32'd99; out_ready = 1'b1;
    chk("t3_full_fill", fill_level, 4);
    chk("t3_full_ready", in_ready, 0);
    step();
    chk("t3_full_pop_fill", fill_level, 3);
    chk("t3_full_pop_ready", in_ready, 1);
    in_valid = 1'b0;
    for (int k = 17; k < 20; k++) begin
      chk("t3_drain", out_result, 32'(k));
      step();
    end
    chk("t3_drain_fill", fill_level, 0);

    // random stalls across several pointer wraps
    q.delete();
    pushed = 0; popped = 0; cyc = 0;
    while ((popped < 10) && (cyc < 300)) begin
      in_valid  = (pushed < 10) && ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_result = 32'hA500_0000 + 32'(pushed * 3);
      chk("t4_valid", out_valid, (q.size() != 0));
      if (q.size() != 0) chk("t4_data", out_result, q[0]);
      mp   = in_valid && (q.size() != 4);
      mpop = (q.size() != 0) && out_ready;
      step();
      if (mpop) begin
        void'(q.pop_front());
        popped++;
      end
      if (mp) begin
        q.push_back(in_result);
        pushed++;
      end
      cyc++;
    end
    chk("t4_all_popped", 64'(popped), 10);
    in_valid = 1'b0;

    // saturating counters and clear priority
    out_ready = 1'b1; cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    chk("t5_clear_ovf", ovf_count, 0);
    chk("t5_clear_err", err_count, 0);
    in_valid = 1'b1; in_overflow = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_result = 32'(100 + i);
      step();
      chk("t5_ovf_sat", ovf_count, (i < 3) ? 64'(i + 1) : 64'd3);
    end
    in_overflow = 1'b0; in_error = 1'b1; in_result = 32'd200;
    step();
    chk("t5_err_one", err_count, 1);
    cnt_clear = 1'b1; in_result = 32'd201;
    step();
    chk("t5_clear_wins_err", err_count, 0);
    chk("t5_clear_wins_ovf", ovf_count, 0);
    chk("t5_fifo_kept", out_result, 32'd201);
    chk("t5_fifo_kept_err", out_error, 1);
    cnt_clear = 1'b0; in_valid = 1'b0; in_error = 1'b0;
    step();
    chk("t5_empty", fill_level, 0);

    // async reset discards held entries before the next edge
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_result = 32'(300 + i);
      step();
    end
    in_valid = 1'b0;
    chk("t6_fill3", fill_level, 3);
    #2;
    rstN = 1'b0;
    #1;
    chk("t6_async_valid", out_valid, 0);
    chk("t6_async_fill", fill_level, 0);
    chk("t6_async_ready", in_ready, 1);
    chk("t6_async_result", out_result, 0);
    step();
    rstN = 1'b1;
    step();
    chk("t6_post_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
